// File: rtl/vip_feeder_if.sv
// Handshake/data bundle between the upstream pair source, the feeder and the
// dot-product stage.
//   src_valid/src_ready/src_v1/src_v2 : upstream pair push channel
//   in_valid/vector_1/vector_2        : burst beats to the dot-product stage
//   vip_out_valid                     : result strobe from the dot-product stage
//   timeout                           : one-cycle pulse, result not received in time
//   fifo_count                        : pairs currently stored
// slave modport is taken by the feeder; master by whatever drives it.
interface vip_feeder_if #(
  parameter int FLOAT_LEN = 32,
  parameter int DEPTH     = 8
);
  logic                   src_valid;
  logic                   src_ready;
  logic [FLOAT_LEN-1:0]   src_v1;
  logic [FLOAT_LEN-1:0]   src_v2;
  logic                   in_valid;
  logic [FLOAT_LEN-1:0]   vector_1;
  logic [FLOAT_LEN-1:0]   vector_2;
  logic                   vip_out_valid;
  logic                   timeout;
  logic [$clog2(DEPTH):0] fifo_count;

  modport slave (
    input  src_valid, src_v1, src_v2, vip_out_valid,
    output src_ready, in_valid, vector_1, vector_2, timeout, fifo_count
  );

  modport master (
    output src_valid, src_v1, src_v2, vip_out_valid,
    input  src_ready, in_valid, vector_1, vector_2, timeout, fifo_count
  );
endinterface

// File: rtl/vip_feeder.sv
// Buffers {v1,v2} float pairs in a FIFO and forwards them to a dot-product
// stage in fixed-length bursts, then waits (bounded) for the result strobe.
//   clk   : single rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : vip_feeder_if.slave (push channel, burst channel, result/timeout, count)
module vip_feeder #(
  parameter int FLOAT_LEN = 32,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 3,
  parameter int WAIT_MAX  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  vip_feeder_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam int PW = 2 * FLOAT_LEN;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
  localparam logic [BW-1:0] BURST_B = BW'(BURST_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  in_valid_q, in_valid_d;
  logic [FLOAT_LEN-1:0]  vec1_q, vec1_d;
  logic [FLOAT_LEN-1:0]  vec2_q, vec2_d;
  logic                  timeout_q, timeout_d;

  logic                  push;
  logic                  pop;
  logic [PW-1:0]         head;

  // Full check uses the registered count only: a same-cycle pop never frees a slot.
  assign push = bus.src_valid && (count_q != DEPTH_C);
  assign head = mem_q[rd_ptr_q];

  // Burst/wait control. SEND never checks occupancy: entry needs BURST_LEN
  // pairs and pushes can only add to that.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    in_valid_d = 1'b0;
    vec1_d     = '0;
    vec2_d     = '0;
    timeout_d  = 1'b0;
    beat_d     = beat_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        if (count_q >= BURST_C) begin
          pop              = 1'b1;
          in_valid_d       = 1'b1;
          {vec1_d, vec2_d} = head;
          beat_d           = BW'(1);
          state_d          = SEND;
        end
      end
      SEND: begin
        if (beat_q < BURST_B) begin
          pop              = 1'b1;
          in_valid_d       = 1'b1;
          {vec1_d, vec2_d} = head;
          beat_d           = beat_q + BW'(1);
        end else begin
          beat_d  = '0;
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A result strobe on the expiry cycle wins over the timeout.
        if (bus.vip_out_valid) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.src_v1, bus.src_v2};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
      in_valid_q <= 1'b0;
      vec1_q     <= '0;
      vec2_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
      in_valid_q <= in_valid_d;
      vec1_q     <= vec1_d;
      vec2_q     <= vec2_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.src_ready  = (count_q != DEPTH_C);
  assign bus.in_valid   = in_valid_q;
  assign bus.vector_1   = vec1_q;
  assign bus.vector_2   = vec2_q;
  assign bus.timeout    = timeout_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_vip_feeder.sv
// Self-checking bench for vip_feeder: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_vip_feeder;
  localparam int FLOAT_LEN = 32;
  localparam int DEPTH     = 8;
  localparam int BURST_LEN = 3;
  localparam int WAIT_MAX  = 15;

  logic clk;
  logic rst_n;

  vip_feeder_if #(.FLOAT_LEN(FLOAT_LEN), .DEPTH(DEPTH)) bus ();

  vip_feeder #(
    .FLOAT_LEN(FLOAT_LEN),
    .DEPTH(DEPTH),
    .BURST_LEN(BURST_LEN),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored pairs plus the number of edges since
  // the current burst began (-1 when no burst/wait is in progress).
  logic [63:0] q[$];
  int          rel = -1;
  logic        m_in_valid = 1'b0;
  logic [31:0] m_v1 = '0;
  logic [31:0] m_v2 = '0;
  logic        m_timeout = 1'b0;

  logic [63:0] beat_log[$];
  int          tpulses = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_edge();
    bit          was_full;
    logic [63:0] h;
    int          t;
    if (!rst_n) begin
      q.delete();
      rel        = -1;
      m_in_valid = 1'b0;
      m_v1       = '0;
      m_v2       = '0;
      m_timeout  = 1'b0;
      return;
    end
    was_full   = (q.size() == DEPTH);
    m_in_valid = 1'b0;
    m_v1       = '0;
    m_v2       = '0;
    m_timeout  = 1'b0;
    if (rel < 0) begin
      if (q.size() >= BURST_LEN) begin
        rel = 0;
        h = q.pop_front();
        m_in_valid = 1'b1;
        {m_v1, m_v2} = h;
      end
    end else begin
      rel++;
      if (rel < BURST_LEN) begin
        h = q.pop_front();
        m_in_valid = 1'b1;
        {m_v1, m_v2} = h;
      end else if (rel > BURST_LEN) begin
        t = rel - BURST_LEN - 1;  // cycles spent waiting before this edge
        if (bus.vip_out_valid) begin
          rel = -1;
        end else if (t == WAIT_MAX - 1) begin
          rel = -1;
          m_timeout = 1'b1;
        end
      end
    end
    if (bus.src_valid && !was_full) q.push_back({bus.src_v1, bus.src_v2});
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("in_valid",   64'(bus.in_valid),   64'(m_in_valid));
    chk("vector_1",   64'(bus.vector_1),   64'(m_v1));
    chk("vector_2",   64'(bus.vector_2),   64'(m_v2));
    chk("timeout",    64'(bus.timeout),    64'(m_timeout));
    chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
    chk("src_ready",  64'(bus.src_ready),  64'(q.size() != DEPTH));
    if (bus.in_valid) beat_log.push_back({bus.vector_1, bus.vector_2});
    if (bus.timeout) tpulses++;
  endtask

  task automatic drive_rand(input int pv, input int po);
    bus.src_valid     = ($urandom_range(99) < pv);
    bus.src_v1        = $urandom;
    bus.src_v2        = $urandom;
    bus.vip_out_valid = ($urandom_range(99) < po);
  endtask

  logic [31:0] a1[3];
  logic [31:0] a2[3];
  bit          found;

  initial begin
    a1 = '{32'h3F800000, 32'h40400000, 32'h40A00000};
    a2 = '{32'h40000000, 32'h40800000, 32'h40C00000};
    rst_n             = 1'b0;
    bus.src_valid     = 1'b0;
    bus.src_v1        = '0;
    bus.src_v2        = '0;
    bus.vip_out_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Three back-to-back pushes -> three beats in order.
    for (int i = 0; i < 3; i++) begin
      bus.src_valid = 1'b1;
      bus.src_v1    = a1[i];
      bus.src_v2    = a2[i];
      step();
    end
    bus.src_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("burst_len", 64'(beat_log.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < beat_log.size()) chk("float_beat", beat_log[i], {a1[i], a2[i]});
    end

    // No result: exactly one timeout pulse.
    for (int i = 0; i < 20; i++) step();
    chk("timeout_pulses", 64'(tpulses), 64'(1));

    // Push faster than drained with no results -> FIFO fills, extra ignored.
    for (int i = 0; i < 24; i++) begin
      drive_rand(100, 0);
      step();
    end

    // Result strobe 4 cycles into WAIT with pairs queued.
    bus.src_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (rel == BURST_LEN + 4) found = 1'b1;
      else step();
    end
    chk("wait_entry_found", 64'(found), 64'(1));
    bus.vip_out_valid = 1'b1;
    step();
    bus.vip_out_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive_rand(55, 8);
      step();
    end

    // Reset on the second burst beat.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rel == 1) found = 1'b1;
      else begin
        drive_rand(70, 0);
        step();
      end
    end
    chk("second_beat_found", 64'(found), 64'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_rand(0, 0);
    step();
    chk("ready_after_reset", 64'(bus.src_ready), 64'(1));
    for (int i = 0; i < 200; i++) begin
      drive_rand(60, 10);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
